sparse_encoder: RTL and testbench

Run-length encoder for sparse weight/activation vectors, the write-side counterpart of the decoder. It consumes a dense element stream (one value per index) and emits one (skip, value) record per nonzero element into the SRAM write path. skip is the number of zero elements since the previous emitted record. Per-vector status (nonzero count, done pulse) is provided for the MAC controller.

---
 rtl/sparse_mac_pkg.sv | 22 ++
 rtl/sparse_enc_outreg.sv | 44 ++++
 rtl/sparse_encoder.sv | 90 +++++++++
 tb/tb_sparse_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_mac_pkg.sv
// Types and widths shared by the sparse MAC encoder and decoder.
// A record is {skip, value}: skip zeros precede value at the next index.
package sparse_mac_pkg;

  localparam int VALUE_W  = 8;
  localparam int SKIP_W   = 4;
  localparam int SKIP_MAX = (1 << SKIP_W) - 1;

  typedef struct packed {
    logic [SKIP_W-1:0]  skip;
    logic [VALUE_W-1:0] value;
  } sram_data_t;

  function automatic sram_data_t make_rec(input logic [SKIP_W-1:0] skip,
                                          input logic [VALUE_W-1:0] value);
    sram_data_t r;
    r.skip  = skip;
    r.value = value;
    return r;
  endfunction

endpackage

// File: rtl/sparse_enc_outreg.sv
// Single-stage valid/ready output register; contents hold while stalled,
// and a load in the same cycle as a handshake replaces the record with no bubble.
module sparse_enc_outreg
  import sparse_mac_pkg::*;
(
  input  logic       mac_clk,
  input  logic       mac_rst,
  input  logic       load_i,
  input  sram_data_t data_i,
  output logic       in_ready_o,
  output logic       valid_o,
  input  logic       ready_i,
  output sram_data_t data_o
);

  logic       valid_q, valid_d;
  sram_data_t data_q, data_d;

  assign in_ready_o = !valid_q || ready_i;
  assign valid_o    = valid_q;
  assign data_o     = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge mac_clk or posedge mac_rst) begin
    if (mac_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sparse_encoder.sv
// Run-length encoder: dense element stream in, one {skip, value} record per
// nonzero (or per full zero run) out, plus per-vector nonzero count.
module sparse_encoder
  import sparse_mac_pkg::*;
#(
  parameter int NNZ_W = 16
) (
  input  logic               mac_clk,
  input  logic               mac_rst,
  input  logic               dense_valid_i,
  output logic               dense_ready_o,
  input  logic [VALUE_W-1:0] dense_value_i,
  input  logic               dense_last_i,
  output logic               sram_valid_o,
  input  logic               sram_ready_i,
  output sram_data_t         sram_data_o,
  output logic               vec_done_o,
  output logic [NNZ_W-1:0]   vec_nnz_o
);

  logic [SKIP_W-1:0] zrun_q, zrun_d;
  logic [NNZ_W-1:0]  nnz_q, nnz_d;
  logic [NNZ_W-1:0]  vec_nnz_q, vec_nnz_d;
  logic              done_q, done_d;

  logic              out_ready;
  logic              accept;
  logic              is_nz;
  logic              is_filler;
  logic              load;
  logic [NNZ_W-1:0]  nnz_inc;
  sram_data_t        rec;

  // Hold off the producer while reset is asserted, even though the
  // output register is already empty.
  assign dense_ready_o = !mac_rst && out_ready;
  assign accept        = dense_valid_i && dense_ready_o;
  assign is_nz         = (dense_value_i != '0);
  assign is_filler     = !is_nz && (zrun_q == SKIP_W'(SKIP_MAX));
  assign load          = accept && (is_nz || is_filler);
  assign rec           = make_rec(zrun_q, is_nz ? dense_value_i : '0);
  assign nnz_inc       = (load && (nnz_q != '1)) ? nnz_q + 1'b1 : nnz_q;

  always_comb begin
    zrun_d    = zrun_q;
    nnz_d     = nnz_q;
    vec_nnz_d = vec_nnz_q;
    done_d    = 1'b0;
    if (accept) begin
      zrun_d = load ? '0 : zrun_q + 1'b1;
      nnz_d  = nnz_inc;
      // Trailing zeros of a vector are simply dropped.
      if (dense_last_i) begin
        zrun_d    = '0;
        nnz_d     = '0;
        vec_nnz_d = nnz_inc;
        done_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge mac_clk or posedge mac_rst) begin
    if (mac_rst) begin
      zrun_q    <= '0;
      nnz_q     <= '0;
      vec_nnz_q <= '0;
      done_q    <= 1'b0;
    end else begin
      zrun_q    <= zrun_d;
      nnz_q     <= nnz_d;
      vec_nnz_q <= vec_nnz_d;
      done_q    <= done_d;
    end
  end

  assign vec_done_o = done_q;
  assign vec_nnz_o  = vec_nnz_q;

  sparse_enc_outreg u_outreg (
    .mac_clk    (mac_clk),
    .mac_rst    (mac_rst),
    .load_i     (load),
    .data_i     (rec),
    .in_ready_o (out_ready),
    .valid_o    (sram_valid_o),
    .ready_i    (sram_ready_i),
    .data_o     (sram_data_o)
  );

endmodule

// File: tb/tb_sparse_encoder.sv
// Directed bench for sparse_encoder: record streams, vector status,
// backpressure hold, and reset mid-stream.
module tb_sparse_encoder;
  import sparse_mac_pkg::*;

  logic               mac_clk = 1'b0;
  logic               mac_rst;
  logic               dense_valid_i;
  logic               dense_ready_o;
  logic [VALUE_W-1:0] dense_value_i;
  logic               dense_last_i;
  logic               sram_valid_o;
  logic               sram_ready_i;
  sram_data_t         sram_data_o;
  logic               vec_done_o;
  logic [15:0]        vec_nnz_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rand_mode = 0;

  sram_data_t  got_q[$];
  sram_data_t  exp_q[$];
  logic [15:0] done_q[$];
  logic [15:0] exp_done[$];

  bit         prev_stall = 0;
  sram_data_t prev_data;

  sparse_encoder #(.NNZ_W(16)) dut (
    .mac_clk       (mac_clk),
    .mac_rst       (mac_rst),
    .dense_valid_i (dense_valid_i),
    .dense_ready_o (dense_ready_o),
    .dense_value_i (dense_value_i),
    .dense_last_i  (dense_last_i),
    .sram_valid_o  (sram_valid_o),
    .sram_ready_i  (sram_ready_i),
    .sram_data_o   (sram_data_o),
    .vec_done_o    (vec_done_o),
    .vec_nnz_o     (vec_nnz_o)
  );

  always #5 mac_clk = ~mac_clk;
  always @(posedge mac_clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Collect handshakes, done pulses, and check hold-under-stall.
  always @(negedge mac_clk) begin
    if (mac_rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {19'd0, sram_valid_o, sram_data_o}, {19'd0, 1'b1, prev_data});
      if (sram_valid_o && sram_ready_i) got_q.push_back(sram_data_o);
      if (vec_done_o) done_q.push_back(vec_nnz_o);
      prev_stall = sram_valid_o && !sram_ready_i;
      prev_data  = sram_data_o;
    end
  end

  task automatic step();
    @(posedge mac_clk);
    #1;
    if (rand_mode) sram_ready_i = ($urandom_range(0, 9) < 6);
  endtask

  task automatic send(input logic [7:0] v, input logic last);
    bit acc;
    bit ok;
    dense_valid_i = 1'b1;
    dense_value_i = v;
    dense_last_i  = last;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge mac_clk);
      acc = dense_ready_o;
      step();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    dense_valid_i = 1'b0;
    dense_last_i  = 1'b0;
  endtask

  task automatic expect_rec(input int skip, input int value);
    exp_q.push_back(make_rec(SKIP_W'(skip), VALUE_W'(value)));
  endtask

  task automatic check_all(input string name);
    bit drained;
    drained = 0;
    for (int i = 0; i < 300; i++) begin
      if (!sram_valid_o) begin
        drained = 1;
        break;
      end
      step();
    end
    step();
    if (!drained) chk({name, "_drain_timeout"}, 32'd0, 32'd1);
    chk({name, "_rec_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_rec%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({name, "_done_count"}, done_q.size(), exp_done.size());
    for (int i = 0; i < done_q.size() && i < exp_done.size(); i++)
      chk($sformatf("%s_nnz%0d", name, i), 32'(done_q[i]), 32'(exp_done[i]));
    $display("%s: %0d records, %0d vectors", name, got_q.size(), done_q.size());
    got_q.delete(); exp_q.delete(); done_q.delete(); exp_done.delete();
  endtask

  initial begin
    logic [7:0]  vec[64];
    logic [7:0]  dec[64];
    int          zr, n, idx, t0, bad;

    mac_rst = 1'b1;
    dense_valid_i = 1'b0;
    dense_value_i = '0;
    dense_last_i  = 1'b0;
    sram_ready_i  = 1'b1;

    repeat (2) @(posedge mac_clk);
    @(negedge mac_clk);
    chk("rst_valid", sram_valid_o, 1'b0);
    chk("rst_data", 32'(sram_data_o), 32'd0);
    chk("rst_done", vec_done_o, 1'b0);
    chk("rst_nnz", vec_nnz_o, 16'd0);
    chk("rst_ready_low", dense_ready_o, 1'b0);
    @(posedge mac_clk); #1;
    mac_rst = 1'b0;
    #1;
    chk("ready_after_rst", dense_ready_o, 1'b1);

    // Skips of 5 and 4 between nonzeros.
    for (int i = 0; i < 5; i++) send(8'd0, 1'b0);
    send(8'd3, 1'b0);
    for (int i = 0; i < 4; i++) send(8'd0, 1'b0);
    send(8'd6, 1'b1);
    expect_rec(5, 3); expect_rec(4, 6); exp_done.push_back(16'd2);
    check_all("t1_skip");
    chk("t1_nnz_held", vec_nnz_o, 16'd2);

    // Back-to-back nonzeros: one-cycle latency, one element per cycle.
    t0 = cyc;
    send(8'd9, 1'b0);
    chk("t2_latency", {19'd0, sram_valid_o, sram_data_o}, {19'd0, 1'b1, 4'd0, 8'd9});
    send(8'd0, 1'b0);
    send(8'd1, 1'b0);
    send(8'd7, 1'b1);
    chk("t2_throughput", cyc - t0, 32'd4);
    expect_rec(0, 9); expect_rec(1, 1); expect_rec(0, 7); exp_done.push_back(16'd3);
    check_all("t2_dense");

    // Zero run longer than SKIP_MAX forces a filler record at index 15.
    for (int i = 0; i < 17; i++) send(8'd0, 1'b0);
    send(8'd1, 1'b1);
    expect_rec(15, 0); expect_rec(1, 1); exp_done.push_back(16'd2);
    check_all("t3_filler");

    // Trailing zeros dropped, zero run cleared across vectors.
    send(8'd4, 1'b0);
    send(8'd0, 1'b0);
    send(8'd0, 1'b1);
    send(8'd2, 1'b1);
    expect_rec(0, 4); expect_rec(0, 2);
    exp_done.push_back(16'd1); exp_done.push_back(16'd1);
    check_all("t4_trail");

    // Random backpressure on a random 64-element vector.
    for (int i = 0; i < 64; i++)
      vec[i] = ($urandom_range(0, 99) < 30) ? 8'($urandom_range(1, 255)) : 8'd0;
    zr = 0; n = 0;
    for (int i = 0; i < 64; i++) begin
      if (vec[i] != 0) begin
        expect_rec(zr, vec[i]); zr = 0; n++;
      end else if (zr == SKIP_MAX) begin
        expect_rec(SKIP_MAX, 0); zr = 0; n++;
      end else begin
        zr++;
      end
    end
    exp_done.push_back(16'(n));
    rand_mode = 1;
    for (int i = 0; i < 64; i++) send(vec[i], i == 63);
    for (int i = 0; i < 64; i++) dec[i] = 8'd0;
    // Decode what is collected so far plus any record still to drain.
    rand_mode = 0;
    sram_ready_i = 1'b1;
    repeat (3) step();
    idx = 0;
    foreach (got_q[i]) begin
      idx += int'(got_q[i].skip);
      if (idx < 64 && got_q[i].value != 0) dec[idx] = got_q[i].value;
      idx++;
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (dec[i] !== vec[i]) bad++;
    chk("t5_decode_bad_idx", bad, 32'd0);
    check_all("t5_random");

    // Reset while a record is held under backpressure.
    sram_ready_i = 1'b0;
    send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0);
    send(8'd5, 1'b0);
    chk("t6_held", {19'd0, sram_valid_o, sram_data_o}, {19'd0, 1'b1, 4'd3, 8'd5});
    step();
    #2 mac_rst = 1'b1;
    #1;
    chk("t6_rst_valid", sram_valid_o, 1'b0);
    chk("t6_rst_data", 32'(sram_data_o), 32'd0);
    @(posedge mac_clk); #1;
    mac_rst = 1'b0;
    sram_ready_i = 1'b1;
    got_q.delete(); done_q.delete();
    send(8'd0, 1'b0);
    send(8'd8, 1'b1);
    expect_rec(1, 8); exp_done.push_back(16'd1);
    check_all("t6_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
